// File: rtl/k_and_s_pkg.sv
// ----------------------------------------------------------------------------
// k_and_s_pkg
//   Shared types and constants for the K&S processor top level.
//   This slice carries the boot-loader pieces: the loader FSM state encoding,
//   the number of stream bytes per RAM word and the run-cycle counter width.
// ----------------------------------------------------------------------------
package k_and_s_pkg;

    // Loader FSM states. Prefixed so they cannot collide with the
    // control_unit state names that live in this same package.
    typedef enum logic [2:0] {
        LD_GET_COUNT,
        LD_GET_HI,
        LD_GET_LO,
        LD_WRITE,
        LD_RELEASE,
        LD_RUN,
        LD_HALTED
    } loader_state_t;

    // Program words arrive high byte first, two bytes per word.
    localparam int LOADER_BYTES_PER_WORD = 2;

    // Width of the saturating run-cycle counter.
    localparam int RUN_CNT_W = 16;

endpackage : k_and_s_pkg

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//   Boot sequencer for the K&S processor. Out of reset it holds the core in
//   reset, owns the program RAM bus (mem_sel=1) and fills the RAM from a
//   valid/ready byte stream: one count byte N (0 means a full RAM), then
//   2*N data bytes, high byte first. It then releases the core, counts cycles
//   until the core raises halt, and can be re-armed with reload.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_data  stream byte offered
//   in_ready          byte accepted this cycle (decoded from state only)
//   ram_addr/ram_wdata/ram_write_enable
//                     loader side of the RAM bus, one write strobe per word
//   mem_sel           1 = loader owns the RAM bus, 0 = core owns it
//   core_rst_n        registered active-low reset to the core
//   halt              core halt flag, sampled only while running
//   reload            single-cycle request to load a new program
//   halted            core has halted since the last release
//   run_cycles        cycles spent running, saturating
// ----------------------------------------------------------------------------
module program_loader
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_write_enable,
    output logic                 mem_sel,
    output logic                 core_rst_n,
    input  logic                 halt,
    input  logic                 reload,
    output logic                 halted,
    output logic [RUN_CNT_W-1:0] run_cycles
);

    localparam int BYTE_W = DATA_W / LOADER_BYTES_PER_WORD;

    localparam logic [ADDR_W-1:0]    IDX_ONE = ADDR_W'(1);
    localparam logic [RUN_CNT_W-1:0] RUN_ONE = RUN_CNT_W'(1);
    localparam logic [RUN_CNT_W-1:0] RUN_MAX = '1;

    loader_state_t         state_q, state_d;

    logic [ADDR_W-1:0]     last_idx_q;   // index of the final word (N-1 mod 2^ADDR_W)
    logic [ADDR_W-1:0]     word_idx_q;
    logic [BYTE_W-1:0]     hi_q;
    logic [BYTE_W-1:0]     lo_q;
    logic [RUN_CNT_W-1:0]  run_cnt_q;
    logic                  core_rst_n_q;
    logic                  mem_sel_q;
    logic                  halted_q;

    // Datapath controls decoded by the FSM.
    logic                  latch_count;
    logic                  latch_hi;
    logic                  latch_lo;
    logic                  idx_inc;
    logic                  run_clr;
    logic                  run_inc;
    logic                  core_active_d;

    // ------------------------------------------------------------------
    // Next-state and control decode.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so
        // no path through the block leaves one unassigned and infers a latch.
        state_d          = state_q;
        in_ready         = 1'b0;
        ram_write_enable = 1'b0;
        latch_count      = 1'b0;
        latch_hi         = 1'b0;
        latch_lo         = 1'b0;
        idx_inc          = 1'b0;
        run_clr          = 1'b0;
        run_inc          = 1'b0;

        unique case (state_q)
            LD_GET_COUNT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    latch_count = 1'b1;
                    state_d     = LD_GET_HI;
                end
            end

            LD_GET_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    latch_hi = 1'b1;
                    state_d  = LD_GET_LO;
                end
            end

            LD_GET_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    latch_lo = 1'b1;
                    state_d  = LD_WRITE;
                end
            end

            LD_WRITE: begin
                ram_write_enable = 1'b1;
                if (word_idx_q == last_idx_q) begin
                    state_d = LD_RELEASE;
                end else begin
                    idx_inc = 1'b1;
                    state_d = LD_GET_HI;
                end
            end

            LD_RELEASE: begin
                run_clr = 1'b1;
                state_d = LD_RUN;
            end

            LD_RUN: begin
                // reload has priority over a halt in the same cycle; the
                // cycle in which either is sampled is not counted.
                if (reload) begin
                    state_d = LD_GET_COUNT;
                end else if (halt) begin
                    state_d = LD_HALTED;
                end else begin
                    run_inc = 1'b1;
                end
            end

            LD_HALTED: begin
                if (reload) begin
                    state_d = LD_GET_COUNT;
                end
            end

            default: begin
                state_d = LD_GET_COUNT;
            end
        endcase
    end

    // The core runs in exactly these two states; core_rst_n, mem_sel and
    // halted are registered from the next state so they change together with
    // the state register and never glitch.
    assign core_active_d = (state_d == LD_RUN) || (state_d == LD_HALTED);

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q <= LD_GET_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Word index, count and byte latches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx_q <= '0;
            word_idx_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            if (latch_count) begin
                // A count of 0 wraps to all-ones, i.e. a full RAM.
                last_idx_q <= in_data[ADDR_W-1:0] - IDX_ONE;
                word_idx_q <= '0;
            end else if (idx_inc) begin
                word_idx_q <= word_idx_q + IDX_ONE;
            end

            if (latch_hi) begin
                hi_q <= in_data;
            end
            if (latch_lo) begin
                lo_q <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run-cycle counter: cleared on release, saturating while running,
    // otherwise held (frozen on halt, kept across a reload until release).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
        end else if (run_clr) begin
            run_cnt_q <= '0;
        end else if (run_inc && (run_cnt_q != RUN_MAX)) begin
            run_cnt_q <= run_cnt_q + RUN_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Core handoff registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n_q <= 1'b0;
            mem_sel_q    <= 1'b1;
            halted_q     <= 1'b0;
        end else begin
            core_rst_n_q <= core_active_d;
            mem_sel_q    <= !core_active_d;
            halted_q     <= (state_d == LD_HALTED);
        end
    end

    // The address and data registers only change outside WRITE, so they can
    // drive the bus directly; the strobe qualifies them.
    assign ram_addr   = word_idx_q;
    assign ram_wdata  = {hi_q, lo_q};
    assign core_rst_n = core_rst_n_q;
    assign mem_sel    = mem_sel_q;
    assign halted     = halted_q;
    assign run_cycles = run_cnt_q;

endmodule : program_loader

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader. A monitor keeps a RAM image and a log
//   of write addresses; the main sequence streams programs, drives halt and
//   reload, and checks outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_write_enable;
    logic              mem_sel;
    logic              core_rst_n;
    logic              halt;
    logic              reload;
    logic              halted;
    logic [15:0]       run_cycles;

    program_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_write_enable (ram_write_enable),
        .mem_sel          (mem_sel),
        .core_rst_n       (core_rst_n),
        .halt             (halt),
        .reload           (reload),
        .halted           (halted),
        .run_cycles       (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_assert = 0;
    int                n_fail   = 0;
    int                n_xfer   = 0;
    logic [15:0]       mem [32];
    logic [ADDR_W-1:0] wr_addr_q [$];

    // Monitor: sampled 1 time unit after the falling edge, when inputs
    // (driven on the falling edge) and DUT outputs are both settled.
    always @(negedge clk) begin
        #1;
        if (rst_n && in_valid && in_ready) n_xfer++;
        if (rst_n && ram_write_enable) begin
            mem[ram_addr] = ram_wdata;
            wr_addr_q.push_back(ram_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte (after an optional gap) and hold it until accepted.
    // Returns on the falling edge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count falling edges until core_rst_n is seen high (bounded).
    task automatic wait_release(output int cycles);
        cycles = 0;
        while (!core_rst_n && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"},   {31'd0, in_ready},         32'd1);
        check({pfx, "_core_rst_n"}, {31'd0, core_rst_n},       32'd0);
        check({pfx, "_mem_sel"},    {31'd0, mem_sel},          32'd1);
        check({pfx, "_we"},         {31'd0, ram_write_enable}, 32'd0);
        check({pfx, "_addr"},       {27'd0, ram_addr},         32'd0);
        check({pfx, "_wdata"},      {16'd0, ram_wdata},        32'd0);
        check({pfx, "_halted"},     {31'd0, halted},           32'd0);
        check({pfx, "_run_cycles"}, {16'd0, run_cycles},       32'd0);
    endtask

    initial begin
        int  rel;
        bit  addr_ok;
        logic [7:0] b;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        halt     = 1'b0;
        reload   = 1'b0;

        // ---------------- reset values ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- two-word program ----------------
        wr_addr_q.delete();
        n_xfer = 0;
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        // Now in WRITE of the last word.
        check("t1_we_last",    {31'd0, ram_write_enable}, 32'd1);
        check("t1_addr_last",  {27'd0, ram_addr},         32'd1);
        check("t1_wdata_last", {16'd0, ram_wdata},        32'h0000ABCD);
        check("t1_ready_wr",   {31'd0, in_ready},         32'd0);
        wait_release(rel);
        check("t1_release_lat", rel, 2);
        check("t1_mem_sel",     {31'd0, mem_sel}, 32'd0);
        check("t1_mem0",        {16'd0, mem[0]},  32'h00001234);
        check("t1_mem1",        {16'd0, mem[1]},  32'h0000ABCD);
        check("t1_nwrites",     wr_addr_q.size(), 2);
        check("t1_wr_order",    {27'd0, wr_addr_q[1]}, 32'd1);
        check("t1_xfers",       n_xfer, 5);
        check("t1_run_start",   {16'd0, run_cycles}, 32'd0);

        // ---------------- halt after 10 run cycles ----------------
        repeat (10) @(negedge clk);
        check("h_run10_pre", {16'd0, run_cycles}, 32'd10);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("h_halted",     {31'd0, halted},     32'd1);
        check("h_run10",      {16'd0, run_cycles}, 32'd10);
        check("h_core_on",    {31'd0, core_rst_n}, 32'd1);
        repeat (3) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        check("h_run_frozen", {16'd0, run_cycles}, 32'd10);
        check("h_still_halt", {31'd0, halted},     32'd1);
        check("h_ready_off",  {31'd0, in_ready},   32'd0);

        // ---------------- reload from HALTED, one-word program ----------------
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("r_core_rst",  {31'd0, core_rst_n}, 32'd0);
        check("r_mem_sel",   {31'd0, mem_sel},    32'd1);
        check("r_halted",    {31'd0, halted},     32'd0);
        check("r_ready",     {31'd0, in_ready},   32'd1);
        check("r_run_hold",  {16'd0, run_cycles}, 32'd10);
        wr_addr_q.delete();
        halt = 1'b1;                 // must be ignored while loading
        send_byte(8'h01, 0);
        send_byte(8'hBE, 0);
        halt = 1'b0;
        send_byte(8'hEF, 0);
        wait_release(rel);
        check("r_release_lat", rel, 2);
        check("r_mem0",        {16'd0, mem[0]}, 32'h0000BEEF);
        check("r_nwrites",     wr_addr_q.size(), 1);
        repeat (3) @(negedge clk);
        check("r_not_halted",  {31'd0, halted},     32'd0);
        check("r_run3",        {16'd0, run_cycles}, 32'd3);

        // ---------------- full RAM (count 0, upper bits set) ----------------
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        wr_addr_q.delete();
        send_byte(8'hE0, 0);
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            send_byte(b, 0);
            send_byte(b ^ 8'hA5, 0);
        end
        wait_release(rel);
        check("f_release_lat", rel, 2);
        check("f_nwrites",     wr_addr_q.size(), 32);
        addr_ok = 1'b1;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != ADDR_W'(i)) addr_ok = 1'b0;
        check("f_addr_order",  {31'd0, addr_ok}, 32'd1);
        check("f_mem0",        {16'd0, mem[0]},  32'h000000A5);
        check("f_mem17",       {16'd0, mem[17]}, 32'h000011B4);
        check("f_mem31",       {16'd0, mem[31]}, 32'h00001FBA);

        // ---------------- reload and halt together in RUN ----------------
        repeat (2) @(negedge clk);
        reload = 1'b1;
        halt   = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        halt   = 1'b0;
        check("rh_ready",    {31'd0, in_ready},   32'd1);
        check("rh_core_rst", {31'd0, core_rst_n}, 32'd0);
        check("rh_mem_sel",  {31'd0, mem_sel},    32'd1);
        check("rh_halted",   {31'd0, halted},     32'd0);
        @(negedge clk);
        check("rh_halted2",  {31'd0, halted},     32'd0);

        // ---------------- gapped three-word program ----------------
        wr_addr_q.delete();
        n_xfer = 0;
        send_byte(8'h03, 2);
        send_byte(8'h11, $urandom_range(0, 3));
        send_byte(8'h11, $urandom_range(0, 3));
        send_byte(8'h22, $urandom_range(0, 3));
        send_byte(8'h22, $urandom_range(0, 3));
        send_byte(8'h33, $urandom_range(0, 3));
        send_byte(8'h33, $urandom_range(0, 3));
        wait_release(rel);
        check("g_release_lat", rel, 2);
        check("g_mem0",        {16'd0, mem[0]}, 32'h00001111);
        check("g_mem1",        {16'd0, mem[1]}, 32'h00002222);
        check("g_mem2",        {16'd0, mem[2]}, 32'h00003333);
        check("g_nwrites",     wr_addr_q.size(), 3);
        check("g_xfers",       n_xfer, 7);

        // Bytes offered while running must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("g_no_consume",  n_xfer, 7);

        // ---------------- async reset during GET_LO ----------------
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h77, 0);
        check("a_ready_lo", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("a");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_addr_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        wait_release(rel);
        check("a_release_lat", rel, 2);
        check("a_mem0",        {16'd0, mem[0]}, 32'h00005AA5);
        check("a_nwrites",     wr_addr_q.size(), 1);
        check("a_mem1_kept",   {16'd0, mem[1]}, 32'h00002222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_program_loader
